// File: rtl/arb_out_fifo.sv
// First-word-fall-through FIFO behind the 3-input priority arbiter.
// The arbiter cannot be stalled, so words arriving while full are dropped and counted.
`ifndef WORD_BITS
`define WORD_BITS 32
`endif

module arb_out_fifo #(
  parameter int unsigned p_st_bits   = `WORD_BITS,
  parameter int unsigned p_depth     = 8,
  parameter int unsigned p_addr_bits = 3,
  parameter int unsigned p_drop_bits = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [p_st_bits-1:0]   iSnk0Data,
  input  logic                   iSnk0Valid,
  output logic [p_st_bits-1:0]   oSrc0Data,
  output logic                   oSrc0Valid,
  input  logic                   iSrc0Ready,
  output logic                   oFull,
  output logic                   oEmpty,
  output logic [p_addr_bits:0]   oCount,
  output logic                   oOverflow,
  input  logic                   iClrOverflow,
  output logic [p_drop_bits-1:0] oDropCnt
);

  localparam int unsigned CntBits = p_addr_bits + 1;
  localparam logic [CntBits-1:0]     DepthVal = CntBits'(p_depth);
  localparam logic [p_drop_bits-1:0] DropMax  = {p_drop_bits{1'b1}};

  logic [p_st_bits-1:0]   mem_q [p_depth];
  logic [p_addr_bits-1:0] wr_ptr_q, wr_ptr_d;
  logic [p_addr_bits-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntBits-1:0]     count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [p_drop_bits-1:0] drop_cnt_q, drop_cnt_d;

  logic full_c, empty_c, push_c, pop_c, drop_c;

  // Status and handshake terms, all derived from registered occupancy
  always_comb begin
    full_c  = (count_q == DepthVal);
    empty_c = (count_q == '0);
    pop_c   = ~empty_c & iSrc0Ready;
    push_c  = iSnk0Valid & (~full_c | pop_c);
    drop_c  = iSnk0Valid & full_c & ~pop_c;
  end

  // Next-state for pointers, occupancy and overflow accounting
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push_c) wr_ptr_d = wr_ptr_q + p_addr_bits'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + p_addr_bits'(1);

    if (push_c && !pop_c)      count_d = count_q + CntBits'(1);
    else if (pop_c && !push_c) count_d = count_q - CntBits'(1);

    // A drop in the same cycle as a clear restarts the count at one
    if (drop_c) begin
      overflow_d = 1'b1;
      if (iClrOverflow)            drop_cnt_d = p_drop_bits'(1);
      else if (drop_cnt_q != DropMax) drop_cnt_d = drop_cnt_q + p_drop_bits'(1);
    end else if (iClrOverflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; the reset-cycle write is suppressed so it cannot leak out
  always_ff @(posedge clk) begin
    if (push_c && !rst) mem_q[wr_ptr_q] <= iSnk0Data;
  end

  always_comb begin
    oSrc0Valid = ~empty_c;
    oSrc0Data  = empty_c ? '0 : mem_q[rd_ptr_q];
    oFull      = full_c;
    oEmpty     = empty_c;
    oCount     = count_q;
    oOverflow  = overflow_q;
    oDropCnt   = drop_cnt_q;
  end

endmodule

// File: tb/tb_arb_out_fifo.sv
// Directed bench for arb_out_fifo: a vector table for basic handshakes, then
// hand-written sequences for wrap, overflow saturation, simultaneous events and reset.
`timescale 1ns/1ps

module tb_arb_out_fifo;

  localparam int unsigned W  = 32;
  localparam int unsigned NV = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  snk_data = '0;
  logic          snk_valid = 1'b0;
  logic [W-1:0]  src_data;
  logic          src_valid;
  logic          src_ready = 1'b0;
  logic          full, empty, ovf;
  logic [3:0]    count;
  logic          clr = 1'b0;
  logic [7:0]    drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_out_fifo #(.p_st_bits(W), .p_depth(8), .p_addr_bits(3), .p_drop_bits(8)) dut (
    .clk(clk), .rst(rst),
    .iSnk0Data(snk_data), .iSnk0Valid(snk_valid),
    .oSrc0Data(src_data), .oSrc0Valid(src_valid), .iSrc0Ready(src_ready),
    .oFull(full), .oEmpty(empty), .oCount(count),
    .oOverflow(ovf), .iClrOverflow(clr), .oDropCnt(drop_cnt)
  );

  typedef struct {
    logic         rst;
    logic         valid;
    logic [31:0]  data;
    logic         ready;
    logic         clr;
    logic         e_valid;
    logic [31:0]  e_data;
    logic [3:0]   e_count;
    logic         e_full;
    logic         e_empty;
    logic         e_ovf;
    logic [7:0]   e_drop;
  } vec_t;

  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic e_valid, input logic [31:0] e_data,
                         input logic [3:0] e_count, input logic e_full, input logic e_empty,
                         input logic e_ovf, input logic [7:0] e_drop);
    chk({name, ".valid"}, 32'(src_valid), 32'(e_valid));
    chk({name, ".data"},  src_data,       e_data);
    chk({name, ".count"}, 32'(count),     32'(e_count));
    chk({name, ".full"},  32'(full),      32'(e_full));
    chk({name, ".empty"}, 32'(empty),     32'(e_empty));
    chk({name, ".ovf"},   32'(ovf),       32'(e_ovf));
    chk({name, ".drop"},  32'(drop_cnt),  32'(e_drop));
  endtask

  // Apply inputs for one cycle, then settle just after the edge
  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic rd, input logic c);
    rst = r; snk_valid = v; snk_data = d; src_ready = rd; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Check the head word before popping it
  task automatic pop_expect(input string name, input logic [31:0] exp);
    chk({name, ".hv"}, 32'(src_valid), 32'd1);
    chk({name, ".hd"}, src_data, exp);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    //          rst  vld  data           rdy  clr   eV   eData          cnt   F    E    ovf  drop
    tbl[0] = '{1'b1,1'b0,32'h0,         1'b0,1'b0, 1'b0,32'h0,         4'd0,1'b0,1'b1,1'b0,8'd0};
    tbl[1] = '{1'b1,1'b0,32'h0,         1'b0,1'b0, 1'b0,32'h0,         4'd0,1'b0,1'b1,1'b0,8'd0};
    tbl[2] = '{1'b0,1'b0,32'h0,         1'b0,1'b0, 1'b0,32'h0,         4'd0,1'b0,1'b1,1'b0,8'd0};
    tbl[3] = '{1'b0,1'b1,32'hA5A5_0001, 1'b0,1'b0, 1'b1,32'hA5A5_0001, 4'd1,1'b0,1'b0,1'b0,8'd0};
    tbl[4] = '{1'b0,1'b0,32'h0,         1'b0,1'b0, 1'b1,32'hA5A5_0001, 4'd1,1'b0,1'b0,1'b0,8'd0};
    tbl[5] = '{1'b0,1'b0,32'h0,         1'b1,1'b0, 1'b0,32'h0,         4'd0,1'b0,1'b1,1'b0,8'd0};
    tbl[6] = '{1'b0,1'b0,32'h0,         1'b1,1'b0, 1'b0,32'h0,         4'd0,1'b0,1'b1,1'b0,8'd0};
    tbl[7] = '{1'b0,1'b1,32'h0000_0001, 1'b1,1'b0, 1'b1,32'h0000_0001, 4'd1,1'b0,1'b0,1'b0,8'd0};
    tbl[8] = '{1'b0,1'b1,32'h0000_0002, 1'b1,1'b0, 1'b1,32'h0000_0002, 4'd1,1'b0,1'b0,1'b0,8'd0};
    tbl[9] = '{1'b0,1'b0,32'h0,         1'b1,1'b0, 1'b0,32'h0,         4'd0,1'b0,1'b1,1'b0,8'd0};

    for (int i = 0; i < int'(NV); i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].ready, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_data, tbl[i].e_count,
              tbl[i].e_full, tbl[i].e_empty, tbl[i].e_ovf, tbl[i].e_drop);
    end

    // Fill and drain three times from a non-zero pointer offset to exercise wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
        chk($sformatf("fill%0d.cnt%0d", r, i), 32'(count), 32'(i + 1));
      end
      chk($sformatf("fill%0d.full", r), 32'(full), 32'd1);
      for (int i = 0; i < 8; i++) pop_expect($sformatf("drain%0d.%0d", r, i), 32'h10 + 32'(i));
      chk($sformatf("drain%0d.empty", r), 32'(empty), 32'd1);
    end

    // Overflow: one drop, then saturation, then clear
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h99, 1'b0, 1'b0);
    chk_all("drop1", 1'b1, 32'h40, 4'd8, 1'b1, 1'b0, 1'b1, 8'd1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 32'h99, 1'b0, 1'b0);
    chk_all("sat", 1'b1, 32'h40, 4'd8, 1'b1, 1'b0, 1'b1, 8'd255);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_all("clr", 1'b1, 32'h40, 4'd8, 1'b1, 1'b0, 1'b0, 8'd0);

    // Full with push and pop together: no drop, pushed word comes out last
    step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0);
    chk_all("fullpp", 1'b1, 32'h41, 4'd8, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i < 8; i++) pop_expect($sformatf("ppdrain%0d", i), 32'h40 + 32'(i));
    pop_expect("ppdrain_last", 32'h20);
    chk("ppdrain.empty", 32'(empty), 32'd1);

    // Drop coinciding with clear: the set wins
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h98, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h98, 1'b0, 1'b0);
    chk("pre_clr.drop", 32'(drop_cnt), 32'd2);
    step(1'b0, 1'b1, 32'h98, 1'b0, 1'b1);
    chk_all("dropclr", 1'b1, 32'h50, 4'd8, 1'b1, 1'b0, 1'b1, 8'd1);

    // Reset mid-stream with a push in the reset cycle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("mid.cnt", 32'(count), 32'd5);
    step(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    chk_all("midrst", 1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 32'h30, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h31, 1'b0, 1'b0);
    chk("post_rst.cnt", 32'(count), 32'd2);
    pop_expect("post_rst.first", 32'h30);
    pop_expect("post_rst.second", 32'h31);
    chk("post_rst.empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
